// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised register bank with load scoreboard.
package regfile_pkg;
    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_IDX   = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits; a set on the same index as a completing write wins.
module regfile_scoreboard #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_idx,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_idx,
    input  logic [ADDR_W-1:0] rd_idx1,
    input  logic [ADDR_W-1:0] rd_idx2,
    output logic              pend1,
    output logic              pend2,
    output logic              pend_any
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                // a new load supersedes the write that completes in the same cycle
                if (set_en && set_idx == ADDR_W'(i))
                    pending[i] <= 1'b1;
                else if (clr_en && clr_idx == ADDR_W'(i))
                    pending[i] <= 1'b0;
            end
        end
    end

    assign pend1    = pending[rd_idx1];
    assign pend2    = pending[rd_idx2];
    assign pend_any = |pending;
endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register bank with post-reset clear sequence and load scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_reg,
    output logic              pend1,
    output logic              pend2,
    output logic              pend_any,
    output logic              init_done
);
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ZI       = ADDR_W'(ZERO_IDX);
    localparam bit                ZR       = (ZERO_REG != 0);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nx;
    logic              ready, clr_we;
    logic              wr_ok, set_ok, byp1, byp2;
    logic              sb_p1, sb_p2, sb_any;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        case (state)
            ST_CLEAR: begin
                clr_cnt_nx = clr_cnt + 1'b1;
                if (clr_cnt == LAST_IDX)
                    state_nx = ST_READY;
            end
            default: state_nx = ST_READY;
        endcase
    end

    always_comb begin
        ready  = (state == ST_READY);
        clr_we = (state == ST_CLEAR) && !rst;
    end

    // init_done is the state flop itself, so it is registered with reset value 0
    assign init_done = ready;

    assign wr_ok  = ready && reg_write && !(ZR && write_reg == ZI);
    assign set_ok = ready && sb_set && !(ZR && sb_reg == ZI);

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we)
                mem[clr_cnt] <= '0;
            else if (wr_ok)
                mem[write_reg] <= write_data;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign byp1 = wr_ok && (write_reg == read_reg1);
    assign byp2 = wr_ok && (write_reg == read_reg2);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        if (ready && !(ZR && read_reg1 == ZI)) read_data1 = mem[read_reg1];
        if (ready && !(ZR && read_reg2 == ZI)) read_data2 = mem[read_reg2];
        if (byp1) read_data1 = write_data;
        if (byp2) read_data2 = write_data;
    end

    regfile_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_ok),
        .set_idx  (sb_reg),
        .clr_en   (wr_ok),
        .clr_idx  (write_reg),
        .rd_idx1  (read_reg1),
        .rd_idx2  (read_reg2),
        .pend1    (sb_p1),
        .pend2    (sb_p2),
        .pend_any (sb_any)
    );

    // a forwarded write resolves the hazard in the same cycle
    assign pend1    = ready && sb_p1 && !byp1;
    assign pend2    = ready && sb_p2 && !byp2;
    assign pend_any = ready && sb_any;
endmodule

// File: tb/tb_regfile_sb.sv
// Randomised self-checking bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reg_write = 1'b0;
    logic [4:0]  write_reg = '0;
    logic [31:0] write_data = '0;
    logic [4:0]  read_reg1 = '0;
    logic [4:0]  read_reg2 = '0;
    logic [31:0] read_data1, read_data2;
    logic        sb_set = 1'b0;
    logic [4:0]  sb_reg = '0;
    logic        pend1, pend2, pend_any, init_done;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [32];
    bit          pend_m [32];
    bit          ready_m = 1'b0;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk(clk), .rst(rst), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(read_data1), .read_data2(read_data2), .sb_set(sb_set),
        .sb_reg(sb_reg), .pend1(pend1), .pend2(pend2), .pend_any(pend_any),
        .init_done(init_done)
    );

    function automatic bit fwd(input logic [4:0] idx);
`ifdef REGFILE_BYPASS_EN
        return ready_m && reg_write && write_reg == idx && idx != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] idx);
        if (!ready_m) return 32'h0;
        if (fwd(idx)) return write_data;
        return (idx == 0) ? 32'h0 : mem_m[idx];
    endfunction

    function automatic logic exp_pend(input logic [4:0] idx);
        return ready_m && pend_m[idx] && !fwd(idx);
    endfunction

    function automatic logic exp_any();
        bit a = 1'b0;
        for (int i = 0; i < 32; i++) a |= pend_m[i];
        return ready_m && a;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mem_m[i]  = 32'h0;
            pend_m[i] = 1'b0;
        end
    endtask

    // apply the currently driven inputs to the model, then advance one edge
    task automatic tick();
        if (ready_m && reg_write && write_reg != 0) begin
            mem_m[write_reg]  = write_data;
            pend_m[write_reg] = 1'b0;
        end
        if (ready_m && sb_set && sb_reg != 0) pend_m[sb_reg] = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        reg_write = 1'b0;
        sb_set    = 1'b0;
    endtask

    task automatic test_reset();
        int n = 0;
        rst = 1'b1; reg_write = 1'b1; write_reg = 5'd1; write_data = 32'h1234_5678;
        sb_set = 1'b1; sb_reg = 5'd5; read_reg1 = 5'd1; read_reg2 = 5'd5;
        @(posedge clk); #1;
        rst = 1'b0;
        while (!init_done && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (!init_done) begin
                checks++;
                if (read_data1 !== 32'h0 || pend_any !== 1'b0) begin
                    errors++;
                    $display("FAIL clear_outputs cycle %0d got rd1=%h any=%b exp 0/0", n, read_data1, pend_any);
                end
            end
        end
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL init_latency got %0d exp 32", n);
        end
        idle();
        model_clear();
        ready_m = 1'b1;
        #1;
        checks++;
        if (pend_any !== 1'b0) begin
            errors++;
            $display("FAIL reset_pend_any got %b exp 0", pend_any);
        end
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i); read_reg2 = 5'(31 - i); #1;
            checks++;
            if (read_data1 !== exp_rd(read_reg1) || read_data2 !== exp_rd(read_reg2)) begin
                errors++;
                $display("FAIL reset_read idx %0d got %h/%h exp 0", i, read_data1, read_data2);
            end
        end
    endtask

    task automatic test_basic();
        reg_write = 1'b1; write_reg = 5'd8; write_data = 32'h5;
        tick();
        idle(); read_reg1 = 5'd8; read_reg2 = 5'd9; #1;
        checks++;
        if (read_data1 !== 32'h5 || read_data2 !== exp_rd(5'd9)) begin
            errors++;
            $display("FAIL basic_rw got %h/%h exp 00000005/%h", read_data1, read_data2, exp_rd(5'd9));
        end
        reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hDEADBEEF;
        tick();
        idle(); read_reg1 = 5'd0; #1;
        checks++;
        if (read_data1 !== 32'h0) begin
            errors++;
            $display("FAIL zero_reg got %h exp 00000000", read_data1);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] want;
        reg_write = 1'b1; write_reg = 5'd22; write_data = 32'h8;
        tick();
        write_data = 32'hA; read_reg1 = 5'd22; #1;
`ifdef REGFILE_BYPASS_EN
        want = 32'hA;
`else
        want = 32'h8;
`endif
        checks++;
        if (read_data1 !== want || read_data1 !== exp_rd(5'd22)) begin
            errors++;
            $display("FAIL rdw_same_cycle got %h exp %h", read_data1, want);
        end
        tick();
        idle(); #1;
        checks++;
        if (read_data1 !== 32'hA) begin
            errors++;
            $display("FAIL rdw_next_cycle got %h exp 0000000a", read_data1);
        end
    endtask

    task automatic test_scoreboard();
        sb_set = 1'b1; sb_reg = 5'd23;
        tick();
        idle(); read_reg1 = 5'd23; #1;
        checks++;
        if (pend1 !== 1'b1 || pend_any !== 1'b1) begin
            errors++;
            $display("FAIL sb_set got pend1=%b any=%b exp 1/1", pend1, pend_any);
        end
        reg_write = 1'b1; write_reg = 5'd23; write_data = 32'h7;
        tick();
        idle(); #1;
        checks++;
        if (pend1 !== 1'b0 || pend_any !== exp_any() || read_data1 !== 32'h7) begin
            errors++;
            $display("FAIL sb_clear got pend1=%b any=%b rd=%h exp 0/%b/00000007", pend1, pend_any, read_data1, exp_any());
        end
        sb_set = 1'b1; sb_reg = 5'd0;
        tick();
        idle(); read_reg1 = 5'd0; #1;
        checks++;
        if (pend_any !== 1'b0 || pend1 !== 1'b0) begin
            errors++;
            $display("FAIL sb_zero got any=%b pend1=%b exp 0/0", pend_any, pend1);
        end
    endtask

    task automatic test_collision();
        sb_set = 1'b1; sb_reg = 5'd24;
        tick();
        reg_write = 1'b1; write_reg = 5'd24; write_data = 32'h4;
        tick();
        idle(); read_reg1 = 5'd24; #1;
        checks++;
        if (pend1 !== 1'b1 || read_data1 !== 32'h4) begin
            errors++;
            $display("FAIL collide_same got pend1=%b rd=%h exp 1/00000004", pend1, read_data1);
        end
        sb_set = 1'b1; sb_reg = 5'd25;
        reg_write = 1'b1; write_reg = 5'd24; write_data = 32'h4;
        tick();
        idle(); read_reg1 = 5'd24; read_reg2 = 5'd25; #1;
        checks++;
        if (pend1 !== 1'b0 || pend2 !== 1'b1) begin
            errors++;
            $display("FAIL collide_diff got pend24=%b pend25=%b exp 0/1", pend1, pend2);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reg_write  = ($urandom_range(0, 1) == 1);
            write_reg  = 5'($urandom_range(0, 31));
            write_data = $urandom;
            sb_set     = ($urandom_range(0, 2) == 0);
            sb_reg     = 5'($urandom_range(0, 31));
            read_reg1  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
            read_reg2  = ($urandom_range(0, 3) == 0) ? sb_reg : 5'($urandom_range(0, 31));
            #1;
            checks++;
            if (read_data1 !== exp_rd(read_reg1) || read_data2 !== exp_rd(read_reg2) ||
                pend1 !== exp_pend(read_reg1) || pend2 !== exp_pend(read_reg2) ||
                pend_any !== exp_any()) begin
                errors++;
                $display("FAIL random c%0d got %h %h %b%b%b exp %h %h %b%b%b", c,
                         read_data1, read_data2, pend1, pend2, pend_any,
                         exp_rd(read_reg1), exp_rd(read_reg2), exp_pend(read_reg1),
                         exp_pend(read_reg2), exp_any());
            end
            tick();
        end
        idle();
    endtask

    task automatic test_mid_reset();
        int n = 0;
        reg_write = 1'b1; write_reg = 5'd3; write_data = 32'hCAFE0003;
        sb_set = 1'b1; sb_reg = 5'd12;
        tick();
        idle(); read_reg1 = 5'd12; read_reg2 = 5'd3; #1;
        checks++;
        if (pend_any !== 1'b1 || pend1 !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_pend got any=%b pend1=%b exp 1/1", pend_any, pend1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ready_m = 1'b0;
        model_clear();
        checks++;
        if (init_done !== 1'b0 || pend1 !== 1'b0 || pend2 !== 1'b0 || pend_any !== 1'b0 || read_data2 !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset got done=%b p=%b%b%b rd=%h exp 0/000/0", init_done, pend1, pend2, pend_any, read_data2);
        end
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        while (!init_done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL restart_latency got %0d exp 32", n);
        end
        ready_m = 1'b1;
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i); read_reg2 = 5'(i ^ 5'h1F); #1;
            checks++;
            if (read_data1 !== 32'h0 || read_data2 !== 32'h0 || pend1 !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_read idx %0d got %h/%h p=%b exp 0", i, read_data1, read_data2, pend1);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_same_cycle();
        test_scoreboard();
        test_collision();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
